// File: rtl/victim_cache_fa_pkg.sv
// Shared types for the victim cache: FSM states, line type and line geometry.
package vc_pkg;

  localparam int VC_LINE_BYTES = 16;
  localparam int OFFSET_BITS   = $clog2(VC_LINE_BYTES);

  typedef logic [VC_LINE_BYTES*8-1:0] line_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PROBE_RESP = 3'd1,
    S_EVICT_ACK  = 3'd2,
    S_WB_REQ     = 3'd3,
    S_WB_WAIT    = 3'd4
  } state_t;

endpackage

// File: rtl/victim_cache_fa_if.sv
// L1-facing probe/evict channels plus the memory write-back channel of the victim cache.
interface victim_cache_fa_if
  import vc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 28
);

  // Handshakes: a request (probe_valid / evict_valid / wb_req_valid) is held high until
  // its one-cycle response strobe (probe_ready / evict_ack / wb_ack) and dropped the
  // cycle after; the cache accepts L1 requests only while vc_ready is high.
  logic                  vc_ready;
  logic                  vc_probe_valid;
  logic [TAG_WIDTH-1:0]  vc_probe_tag;
  logic                  vc_probe_ready;
  logic                  vc_probe_hit;
  logic                  vc_probe_dirty;
  line_t                 vc_probe_line;
  logic                  vc_evict_valid;
  logic [TAG_WIDTH-1:0]  vc_evict_tag;
  line_t                 vc_evict_line;
  logic                  vc_evict_dirty;
  logic                  vc_evict_ack;
  logic                  wb_req_valid;
  logic [ADDR_WIDTH-1:0] wb_req_addr;
  line_t                 wb_req_wdata;
  logic                  wb_ack;

  modport slave (
    output vc_ready, vc_probe_ready, vc_probe_hit, vc_probe_dirty, vc_probe_line,
    output vc_evict_ack, wb_req_valid, wb_req_addr, wb_req_wdata,
    input  vc_probe_valid, vc_probe_tag, vc_evict_valid, vc_evict_tag,
    input  vc_evict_line, vc_evict_dirty, wb_ack
  );

  modport master (
    input  vc_ready, vc_probe_ready, vc_probe_hit, vc_probe_dirty, vc_probe_line,
    input  vc_evict_ack, wb_req_valid, wb_req_addr, wb_req_wdata,
    output vc_probe_valid, vc_probe_tag, vc_evict_valid, vc_evict_tag,
    output vc_evict_line, vc_evict_dirty, wb_ack
  );

endinterface

// File: rtl/vc_match_enc.sv
// Parallel tag compare over all entries: hit + index, and lowest-index free entry.
module vc_match_enc #(
  parameter int ENTRIES   = 4,
  parameter int TAG_WIDTH = 28,
  parameter int IDX_W     = 2
) (
  input  logic [ENTRIES-1:0]                i_valid,
  input  logic [ENTRIES-1:0][TAG_WIDTH-1:0] i_tags,
  input  logic [TAG_WIDTH-1:0]              i_cmp_tag,
  output logic                              o_hit,
  output logic [IDX_W-1:0]                  o_hit_idx,
  output logic                              o_free_any,
  output logic [IDX_W-1:0]                  o_free_idx
);

  // Scanning downward lets the lowest matching/free index win.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_idx  = '0;
    o_free_any = 1'b0;
    o_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (i_valid[i] && (i_tags[i] == i_cmp_tag)) begin
        o_hit     = 1'b1;
        o_hit_idx = IDX_W'(i);
      end
      if (!i_valid[i]) begin
        o_free_any = 1'b1;
        o_free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/victim_cache_fa.sv
// Fully-associative victim cache behind a direct-mapped L1, exclusive with L1.
// Optional saturating statistics counters when VC_STATS_EN is defined.
module victim_cache_fa
  import vc_pkg::*;
#(
  parameter int ENTRIES    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = VC_LINE_BYTES,
  parameter int TAG_WIDTH  = 28
) (
  input  logic              clk,
  input  logic              rst,
  victim_cache_fa_if.slave  bus,
  output state_t            o_dbg_state
`ifdef VC_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wbs
`endif
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  if ((ADDR_WIDTH != TAG_WIDTH + OFFSET_BITS) || (LINE_BYTES != VC_LINE_BYTES) ||
      (ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_param_check
    $error("victim_cache_fa: inconsistent ENTRIES/ADDR_WIDTH/LINE_BYTES/TAG_WIDTH");
  end

  state_t                            r_state;
  state_t                            w_next_state;
  logic                              r_ready;
  logic [ENTRIES-1:0]                r_valid;
  logic [ENTRIES-1:0]                r_dirty;
  logic [ENTRIES-1:0][TAG_WIDTH-1:0] r_tags;
  line_t                             r_data [ENTRIES];
  logic [IDX_W-1:0]                  r_rr_ptr;
  logic [IDX_W-1:0]                  r_slot;
  logic [TAG_WIDTH-1:0]              r_tag;
  line_t                             r_line;
  logic                              r_new_dirty;
  logic                              r_wb_done;
  logic [ADDR_WIDTH-1:0]             r_wb_addr;
  line_t                             r_wb_data;

  logic [TAG_WIDTH-1:0] w_cmp_tag;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_free_any;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_accept_probe;
  logic                 w_accept_evict;
  logic [IDX_W-1:0]     w_evict_slot;
  logic                 w_use_rr;
  logic                 w_need_wb;
  logic                 w_new_dirty;
  logic                 w_probe_ready;
  logic                 w_evict_ack;
  logic                 w_wb_valid;
  logic                 w_wb_fire;

  // The probe compare runs in PROBE_RESP on the registered tag; everywhere else the
  // encoder looks at the incoming evict tag so slot choice is ready at acceptance.
  assign w_cmp_tag = (r_state == S_PROBE_RESP) ? r_tag : bus.vc_evict_tag;

  vc_match_enc #(
    .ENTRIES   (ENTRIES),
    .TAG_WIDTH (TAG_WIDTH),
    .IDX_W     (IDX_W)
  ) u_match (
    .i_valid    (r_valid),
    .i_tags     (r_tags),
    .i_cmp_tag  (w_cmp_tag),
    .o_hit      (w_hit),
    .o_hit_idx  (w_hit_idx),
    .o_free_any (w_free_any),
    .o_free_idx (w_free_idx)
  );

  assign w_accept_probe = r_ready && (r_state == S_IDLE) && bus.vc_probe_valid;
  assign w_accept_evict = r_ready && (r_state == S_IDLE) && !bus.vc_probe_valid &&
                          bus.vc_evict_valid;

  always_comb begin
    w_evict_slot = r_rr_ptr;
    w_use_rr     = 1'b0;
    w_need_wb    = 1'b0;
    w_new_dirty  = bus.vc_evict_dirty;
    if (w_hit) begin
      w_evict_slot = w_hit_idx;
      w_new_dirty  = r_dirty[w_hit_idx] | bus.vc_evict_dirty;
    end else if (w_free_any) begin
      w_evict_slot = w_free_idx;
    end else begin
      w_use_rr  = 1'b1;
      w_need_wb = r_valid[r_rr_ptr] & r_dirty[r_rr_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == S_IDLE);
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_probe_ready = 1'b0;
    w_evict_ack   = 1'b0;
    w_wb_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept_probe)      w_next_state = S_PROBE_RESP;
        else if (w_accept_evict) w_next_state = w_need_wb ? S_WB_REQ : S_EVICT_ACK;
      end
      S_PROBE_RESP: begin
        w_probe_ready = 1'b1;
        w_next_state  = S_IDLE;
      end
      S_EVICT_ACK: begin
        w_evict_ack  = 1'b1;
        w_next_state = S_IDLE;
      end
      S_WB_REQ: begin
        w_wb_valid   = 1'b1;
        w_next_state = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        // An ack taken in WB_REQ is remembered so the request drops right away.
        w_wb_valid = !r_wb_done;
        if (r_wb_done || bus.wb_ack) w_next_state = S_EVICT_ACK;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_wb_fire = w_wb_valid & bus.wb_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_dirty     <= '0;
      r_rr_ptr    <= '0;
      r_slot      <= '0;
      r_tag       <= '0;
      r_line      <= '0;
      r_new_dirty <= 1'b0;
      r_wb_done   <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
    end else begin
      if (w_accept_probe) r_tag <= bus.vc_probe_tag;
      if (w_accept_evict) begin
        r_tag       <= bus.vc_evict_tag;
        r_line      <= bus.vc_evict_line;
        r_slot      <= w_evict_slot;
        r_new_dirty <= w_new_dirty;
        if (w_use_rr) r_rr_ptr <= r_rr_ptr + 1'b1;
        if (w_need_wb) begin
          r_wb_addr <= {r_tags[r_rr_ptr], {OFFSET_BITS{1'b0}}};
          r_wb_data <= r_data[r_rr_ptr];
        end
      end
      if (r_state == S_WB_REQ)       r_wb_done <= bus.wb_ack;
      else if (r_state != S_WB_WAIT) r_wb_done <= 1'b0;
      // Exclusive with L1: a hit line moves back to L1 and leaves this cache.
      if ((r_state == S_PROBE_RESP) && w_hit) begin
        r_valid[w_hit_idx] <= 1'b0;
        r_dirty[w_hit_idx] <= 1'b0;
      end
      if (r_state == S_EVICT_ACK) begin
        r_valid[r_slot] <= 1'b1;
        r_dirty[r_slot] <= r_new_dirty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_EVICT_ACK) begin
      r_tags[r_slot] <= r_tag;
      r_data[r_slot] <= r_line;
    end
  end

  assign bus.vc_ready       = r_ready;
  assign bus.vc_probe_ready = w_probe_ready;
  assign bus.vc_probe_hit   = w_probe_ready & w_hit;
  assign bus.vc_probe_dirty = w_probe_ready & w_hit & r_dirty[w_hit_idx];
  assign bus.vc_probe_line  = (w_probe_ready && w_hit) ? r_data[w_hit_idx] : '0;
  assign bus.vc_evict_ack   = w_evict_ack;
  assign bus.wb_req_valid   = w_wb_valid;
  assign bus.wb_req_addr    = r_wb_addr;
  assign bus.wb_req_wdata   = r_wb_data;
  assign o_dbg_state        = r_state;

`ifdef VC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbs    <= '0;
    end else begin
      if (w_probe_ready && w_hit && (stat_hits != '1))    stat_hits   <= stat_hits + 1'b1;
      if (w_probe_ready && !w_hit && (stat_misses != '1)) stat_misses <= stat_misses + 1'b1;
      if (w_wb_fire && (stat_wbs != '1))                  stat_wbs    <= stat_wbs + 1'b1;
    end
  end
`else
  logic w_unused_fire;
  assign w_unused_fire = w_wb_fire;
`endif

endmodule

// File: tb/tb_victim_cache_fa.sv
// Directed plus randomized checks of victim_cache_fa against an entry-table reference model.
module tb_victim_cache_fa;
  import vc_pkg::*;

  localparam int ENTRIES = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     errors = 0;
  int     checks = 0;

  victim_cache_fa_if #(.ADDR_WIDTH(32), .TAG_WIDTH(28)) bus ();

  victim_cache_fa #(
    .ENTRIES    (ENTRIES),
    .ADDR_WIDTH (32),
    .LINE_BYTES (16),
    .TAG_WIDTH  (28)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: a table of lines plus the replacement pointer.
  logic        m_valid [ENTRIES];
  logic [27:0] m_tag   [ENTRIES];
  line_t       m_line  [ENTRIES];
  logic        m_dirty [ENTRIES];
  int          m_rr;

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_line[i]  = '0;
    end
    m_rr = 0;
  endfunction

  function automatic void model_probe(input logic [27:0] tag, output logic hit,
                                      output logic dirty, output line_t line);
    hit = 1'b0; dirty = 1'b0; line = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_valid[i] && m_tag[i] == tag) begin
        hit = 1'b1; dirty = m_dirty[i]; line = m_line[i];
        m_valid[i] = 1'b0;
      end
    end
  endfunction

  function automatic void model_evict(input logic [27:0] tag, input line_t line, input logic dirty,
                                      output logic need_wb, output logic [31:0] addr,
                                      output line_t data);
    int   slot = -1;
    logic nd   = dirty;
    need_wb = 1'b0; addr = '0; data = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == tag) begin slot = i; nd = m_dirty[i] | dirty; end
    if (slot < 0)
      for (int i = 0; i < ENTRIES; i++)
        if (!m_valid[i] && slot < 0) slot = i;
    if (slot < 0) begin
      slot = m_rr;
      if (m_dirty[slot]) begin
        need_wb = 1'b1;
        addr    = {m_tag[slot], 4'h0};
        data    = m_line[slot];
      end
      m_rr = (m_rr + 1) % ENTRIES;
    end
    m_valid[slot] = 1'b1; m_tag[slot] = tag; m_line[slot] = line; m_dirty[slot] = nd;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_vc_ready"},    128'(bus.vc_ready), 128'd0);
    check({nm, "_probe_ready"}, 128'(bus.vc_probe_ready), 128'd0);
    check({nm, "_probe_hit"},   128'(bus.vc_probe_hit), 128'd0);
    check({nm, "_probe_dirty"}, 128'(bus.vc_probe_dirty), 128'd0);
    check({nm, "_probe_line"},  bus.vc_probe_line, 128'd0);
    check({nm, "_evict_ack"},   128'(bus.vc_evict_ack), 128'd0);
    check({nm, "_wb_valid"},    128'(bus.wb_req_valid), 128'd0);
    check({nm, "_wb_addr"},     128'(bus.wb_req_addr), 128'd0);
    check({nm, "_wb_wdata"},    bus.wb_req_wdata, 128'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.vc_probe_valid = 1'b0;
    bus.vc_evict_valid = 1'b0;
    bus.wb_ack         = 1'b0;
    #1 check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1 check("ready_at_release", 128'(bus.vc_ready), 128'd0);
    @(negedge clk);
    check("ready_after_release", 128'(bus.vc_ready), 128'd1);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.vc_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 128'(bus.vc_ready), 128'd1);
  endtask

  task automatic do_probe(input logic [27:0] tag, input string nm);
    logic eh, ed;
    line_t el;
    model_probe(tag, eh, ed, el);
    wait_ready();
    bus.vc_probe_valid = 1'b1;
    bus.vc_probe_tag   = tag;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_ready"}, 128'(bus.vc_probe_ready), 128'd1);
    check({nm, "_hit"},   128'(bus.vc_probe_hit), 128'(eh));
    check({nm, "_dirty"}, 128'(bus.vc_probe_dirty), 128'(ed));
    check({nm, "_line"},  bus.vc_probe_line, el);
    check({nm, "_noack"}, 128'(bus.vc_evict_ack), 128'd0);
    @(posedge clk);
    #1 bus.vc_probe_valid = 1'b0;
  endtask

  task automatic do_evict(input logic [27:0] tag, input line_t line, input logic dirty,
                          input int ack_delay, input string nm);
    logic        need_wb;
    logic [31:0] exp_addr;
    line_t       exp_data;
    model_evict(tag, line, dirty, need_wb, exp_addr, exp_data);
    wait_ready();
    bus.vc_evict_valid = 1'b1;
    bus.vc_evict_tag   = tag;
    bus.vc_evict_line  = line;
    bus.vc_evict_dirty = dirty;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_busy"}, 128'(bus.vc_ready), 128'd0);
    if (!need_wb) begin
      check({nm, "_ack_t1"},   128'(bus.vc_evict_ack), 128'd1);
      check({nm, "_no_wb"},    128'(bus.wb_req_valid), 128'd0);
    end else begin
      check({nm, "_ack_early"}, 128'(bus.vc_evict_ack), 128'd0);
      check({nm, "_wb_valid"},  128'(bus.wb_req_valid), 128'd1);
      check({nm, "_wb_addr"},   128'(bus.wb_req_addr), 128'(exp_addr));
      check({nm, "_wb_data"},   bus.wb_req_wdata, exp_data);
      for (int i = 0; i < ack_delay; i++) begin
        @(posedge clk);
        @(negedge clk);
        check({nm, "_wb_hold"},  128'(bus.wb_req_valid), 128'd1);
        check({nm, "_wait_ack"}, 128'(bus.vc_evict_ack), 128'd0);
      end
      bus.wb_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.wb_ack = 1'b0;
      if (ack_delay == 0) begin
        check({nm, "_wb_drop"}, 128'(bus.wb_req_valid), 128'd0);
        check({nm, "_ack_t2"},  128'(bus.vc_evict_ack), 128'd0);
        @(posedge clk);
        @(negedge clk);
      end
      check({nm, "_ack_after_wb"}, 128'(bus.vc_evict_ack), 128'd1);
      check({nm, "_wb_done"},      128'(bus.wb_req_valid), 128'd0);
    end
    @(posedge clk);
    #1 bus.vc_evict_valid = 1'b0;
  endtask

  initial begin
    line_t       l_a, l_d0;
    logic        eh, ed;
    line_t       el;
    logic        nw;
    logic [31:0] ea;
    line_t       edata;

    bus.vc_probe_valid = 1'b0;
    bus.vc_probe_tag   = '0;
    bus.vc_evict_valid = 1'b0;
    bus.vc_evict_tag   = '0;
    bus.vc_evict_line  = '0;
    bus.vc_evict_dirty = 1'b0;
    bus.wb_ack         = 1'b0;
    model_clear();
    l_a  = {16{8'hAA}};
    l_d0 = 128'hD0D0_0000_1111_2222_3333_4444_5555_6666;

    do_reset();
    check("dbg_idle", 128'(dbg_state), 128'(S_IDLE));

    do_probe(28'h0000123, "empty_probe");
    do_evict(28'h0000123, l_a, 1'b1, 0, "evict_aa");
    do_probe(28'h0000123, "probe_aa_hit");
    do_probe(28'h0000123, "probe_aa_again");

    do_evict(28'h0000050, '0, 1'b1, 0, "merge_a");
    do_evict(28'h0000050, 128'h5, 1'b0, 0, "merge_b");
    do_probe(28'h0000050, "merge_probe");

    // Four clean lines, then two more exercise the replacement pointer.
    do_reset();
    for (int i = 0; i < 4; i++)
      do_evict(28'h0000200 + 28'(i), 128'(i + 1), 1'b0, 0, "fill_clean");
    do_evict(28'h0000204, 128'h44, 1'b0, 0, "evict5_clean");
    do_evict(28'h0000205, 128'h55, 1'b0, 0, "evict6_clean");
    do_probe(28'h0000200, "rr_probe_e0");
    do_probe(28'h0000201, "rr_probe_e1");
    do_probe(28'h0000202, "rr_probe_e2");

    // Dirty victim with a slow memory.
    do_reset();
    do_evict(28'h0000010, l_d0, 1'b1, 0, "fill_dirty");
    for (int i = 1; i < 4; i++)
      do_evict(28'h0000010 + 28'(i), 128'(i), 1'b0, 0, "fill_rest");
    do_evict(28'h0000014, 128'h14, 1'b0, 5, "evict_dirty");
    @(negedge clk);
    bus.wb_ack = 1'b1;
    @(negedge clk);
    bus.wb_ack = 1'b0;
    check("stray_wb_ack_noack", 128'(bus.vc_evict_ack), 128'd0);
    check("stray_wb_ack_nowb",  128'(bus.wb_req_valid), 128'd0);
    do_probe(28'h0000010, "probe_written_back");

    // Probe and evict presented together: probe first, evict afterwards.
    do_reset();
    do_evict(28'h0000300, 128'h300, 1'b0, 0, "both_setup");
    model_probe(28'h0000300, eh, ed, el);
    model_evict(28'h0000301, 128'h301, 1'b1, nw, ea, edata);
    wait_ready();
    bus.vc_probe_valid = 1'b1;
    bus.vc_probe_tag   = 28'h0000300;
    bus.vc_evict_valid = 1'b1;
    bus.vc_evict_tag   = 28'h0000301;
    bus.vc_evict_line  = 128'h301;
    bus.vc_evict_dirty = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("both_probe_ready", 128'(bus.vc_probe_ready), 128'd1);
    check("both_probe_hit",   128'(bus.vc_probe_hit), 128'(eh));
    check("both_probe_line",  bus.vc_probe_line, el);
    check("both_no_ack_yet",  128'(bus.vc_evict_ack), 128'd0);
    @(posedge clk);
    #1 bus.vc_probe_valid = 1'b0;
    @(negedge clk);
    check("both_idle_again", 128'(bus.vc_ready), 128'd1);
    check("both_ack_later0", 128'(bus.vc_evict_ack), 128'd0);
    @(posedge clk);
    @(negedge clk);
    check("both_ack_later1", 128'(bus.vc_evict_ack), 128'd1);
    check("both_wb_expect",  128'(bus.wb_req_valid), 128'(nw));
    @(posedge clk);
    #1 bus.vc_evict_valid = 1'b0;
    do_probe(28'h0000301, "both_probe_new");

    // Reset in the middle of a write-back.
    do_reset();
    do_evict(28'h0000010, l_d0, 1'b1, 0, "rwb_fill");
    for (int i = 1; i < 4; i++)
      do_evict(28'h0000010 + 28'(i), 128'(i), 1'b0, 0, "rwb_fill_rest");
    wait_ready();
    bus.vc_evict_valid = 1'b1;
    bus.vc_evict_tag   = 28'h0000014;
    bus.vc_evict_line  = 128'h14;
    bus.vc_evict_dirty = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rwb_req", 128'(bus.wb_req_valid), 128'd1);
    @(posedge clk);
    @(negedge clk);
    check("rwb_wait", 128'(bus.wb_req_valid), 128'd1);
    rst = 1'b1;
    bus.vc_evict_valid = 1'b0;
    #1 check_quiet("rwb_in_reset");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("rwb_ready",  128'(bus.vc_ready), 128'd1);
    check("rwb_no_ack", 128'(bus.vc_evict_ack), 128'd0);
    check("rwb_no_wb",  128'(bus.wb_req_valid), 128'd0);
    do_probe(28'h0000010, "rwb_empty_e0");
    do_probe(28'h0000013, "rwb_empty_e3");

    // Random mix over a small tag pool so hits, merges and dirty victims all occur.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic [27:0] t;
      t = 28'h0000400 + 28'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0)
        do_probe(t, "rnd_probe");
      else
        do_evict(t, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), "rnd_evict");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
